// File: rtl/demux8_collector.sv
// Serial-to-parallel slot collector: routes bit f into slot S of an 8-bit word,
// tracks which slots were written, and offers the word once every slot is filled.
module demux8_collector #(
  parameter bit CLEAR_ON_ACCEPT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f,
  input  logic [2:0] S,
  input  logic       f_valid,
  output logic       f_ready,
  input  logic       flush,
  output logic [7:0] W,
  output logic [7:0] filled,
  output logic       w_valid,
  input  logic       w_ready,
  output logic       dup_err
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_word;
  logic [7:0] r_filled;
  logic       r_w_valid;
  logic       r_dup_err;

  state_t     w_state_nxt;
  logic [7:0] w_word_nxt;
  logic [7:0] w_filled_nxt;
  logic       w_w_valid_nxt;
  logic       w_dup_err_nxt;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_COLLECT;
      r_word    <= 8'h00;
      r_filled  <= 8'h00;
      r_w_valid <= 1'b0;
      r_dup_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_word    <= w_word_nxt;
      r_filled  <= w_filled_nxt;
      r_w_valid <= w_w_valid_nxt;
      r_dup_err <= w_dup_err_nxt;
    end
  end

  // Next-state logic; flush overrides any write or handshake in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_word_nxt    = r_word;
    w_filled_nxt  = r_filled;
    w_w_valid_nxt = r_w_valid;
    w_dup_err_nxt = 1'b0;
    if (flush) begin
      w_state_nxt   = ST_COLLECT;
      w_word_nxt    = 8'h00;
      w_filled_nxt  = 8'h00;
      w_w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (f_valid) begin
            w_word_nxt[S]   = f;
            w_filled_nxt[S] = 1'b1;
            w_dup_err_nxt   = r_filled[S];
            if (w_filled_nxt == 8'hFF) begin
              w_state_nxt   = ST_HOLD;
              w_w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt   = ST_COLLECT;
            end
          end else begin
            w_state_nxt = ST_COLLECT;
          end
        end
        ST_HOLD: begin
          if (w_ready) begin
            w_state_nxt   = ST_COLLECT;
            w_filled_nxt  = 8'h00;
            w_w_valid_nxt = 1'b0;
            if (CLEAR_ON_ACCEPT) begin
              w_word_nxt = 8'h00;
            end else begin
              w_word_nxt = r_word;
            end
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
          w_state_nxt   = ST_COLLECT;
          w_word_nxt    = 8'h00;
          w_filled_nxt  = 8'h00;
          w_w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign f_ready = (r_state == ST_COLLECT);
  assign W       = r_word;
  assign filled  = r_filled;
  assign w_valid = r_w_valid;
  assign dup_err = r_dup_err;

endmodule

// File: doc/demux8_collector.md
DEMUX8_COLLECTOR -- requirements
Module: demux8_collector

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have a parameter CLEAR_ON_ACCEPT, default 1: when 1, W is cleared to 8'h00 on output handshake; when 0, W keeps its value.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port f, input, 1, the serial data bit to be routed.
REQ-005 The block SHALL have port S, input, 3, the destination slot index for f.
REQ-006 The block SHALL have port f_valid, input, 1, meaning f/S are valid this cycle.
REQ-007 The block SHALL have port f_ready, output, 1, meaning the block accepts f/S this cycle.
REQ-008 The block SHALL have port flush, input, 1, synchronous abort of the current collection.
REQ-009 The block SHALL have port W, output, 8, the assembled word; bit S holds the last f written to slot S.
REQ-010 The block SHALL have port filled, output, 8, per-slot written flags for the current word.
REQ-011 The block SHALL have port w_valid, output, 1, meaning W is complete (all 8 slots written).
REQ-012 The block SHALL have port w_ready, input, 1, meaning the consumer accepts W.
REQ-013 The block SHALL have port dup_err, output, 1, a one-cycle pulse when an accepted write targets a slot already written in the current word.

Function
REQ-014 The block SHALL implement two states: COLLECT and HOLD.
REQ-015 The block SHALL drive f_ready = 1 in COLLECT and 0 in HOLD, as a combinational decode of state only.
REQ-016 In COLLECT, on a cycle with f_valid=1, the block SHALL, at the next edge, set W[S] to f and set filled[S] to 1.
REQ-017 An accepted write to a slot whose filled bit is already 1 SHALL overwrite W[S] and assert dup_err for exactly the following cycle; filled is unchanged.
REQ-018 dup_err SHALL be 0 in every cycle not covered by REQ-017.
REQ-019 When an accepted write makes filled equal 8'hFF, the block SHALL, on that same edge, enter HOLD and set w_valid=1, giving one cycle of latency from the last write presented to w_valid.
REQ-020 In HOLD, W, filled and w_valid SHALL be stable until handshake; f_valid SHALL be ignored.
REQ-021 In HOLD, on a cycle with w_ready=1, the block SHALL at the next edge clear filled to 8'h00, clear w_valid, return to COLLECT, and clear W to 8'h00 only if CLEAR_ON_ACCEPT=1.
REQ-022 When w_ready=1 and f_valid=1 in the same HOLD cycle, the block SHALL not write f (f_ready=0); the first write of the next word occurs no earlier than the cycle after the handshake.
REQ-023 w_ready SHALL be ignored in COLLECT.
REQ-024 flush=1 SHALL, at the next edge, clear filled, clear w_valid and dup_err, clear W (regardless of CLEAR_ON_ACCEPT), and force COLLECT.
REQ-025 flush SHALL take priority over any write or handshake in the same cycle.
REQ-026 The order in which slots are filled SHALL be arbitrary; completion depends only on filled=8'hFF.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set state=COLLECT, W=8'h00, filled=8'h00, w_valid=0 and dup_err=0.
REQ-028 Reset SHALL take priority over flush, writes and handshake, including mid-collection and in HOLD.
REQ-029 f_ready SHALL be 1 in the cycle after reset is released.

Verification
REQ-030 The bench SHALL cover in-order fill: write S=0..7 with f = bits of 8'hA5, w_ready=0 → w_valid rises on the edge of the S=7 write; W=8'hA5 and filled=8'hFF are held.
REQ-031 The bench SHALL cover out-of-order fill: S = 7,3,0,5,1,6,2,4 building 8'h3C → W=8'h3C, w_valid=1 only after the 8th write; no dup_err.
REQ-032 The bench SHALL cover duplicate write: write S=2 with f=1, then S=2 with f=0 → W[2]=0, dup_err high for exactly one cycle, filled=8'h04.
REQ-033 The bench SHALL cover handshake collision: in HOLD, apply w_ready=1 and f_valid=1 (S=0, f=1) together → the f write is dropped; the next cycle shows filled=8'h00, w_valid=0, f_ready=1, and W=8'h00 when CLEAR_ON_ACCEPT=1 or the prior value when it is 0.
REQ-034 The bench SHALL cover flush: flush after 5 writes, and flush asserted together with a write → filled=8'h00, W=8'h00, the write is lost; a following full fill completes normally.
REQ-035 The bench SHALL cover reset mid-operation: rst_n=0 in HOLD and again after 3 writes → all outputs at reset values on the next edge; f_ready=1 after release.
